gsim_host_check: RTL and testbench
==================================

// Module: gsim_host_check
// PURPOSE
//  Host-side counterpart of the GSIM solver. Holds a 16-entry b vector and streams
//  it into the solver over the in_en/b_in protocol. Collects the 16 x words presented
//  on out_valid/x_out, then recomputes b' = A*x for the fixed 7-band matrix
//  (diagonal 20, +/-1: -13, +/-2: +6, +/-3: -1) and reports the worst residual |b - A*x|.
//  Sits between the test/system host and one GSIM instance; one solve per solver reset.
// PARAMETERS
//  N        16      vector length; rows 0..N-1, fixed to solver size
//  TOL      40'd64  pass threshold on |residual|, Q16.16 LSBs (64 = 2^-10)
//  TIMEOUT  4096    max cycles in WAIT for first out_valid before abort
// PORTS
//  clk           in   1   rising-edge clock
//  reset         in   1   async active-high reset
//  start         in   1   pulse: begin send/collect/check; honoured only in IDLE
//  b_wr_en       in   1   write b_wr_data to b[b_wr_addr]; ignored unless IDLE
//  b_wr_addr     in   4   b entry index
//  b_wr_data     in   16  signed integer b entry
//  gsim_in_en    out  1   to solver in_en
//  gsim_b_in     out  16  to solver b_in
//  gsim_out_valid in  1   from solver out_valid
//  gsim_x_out    in   32  from solver x_out, signed Q16.16
//  busy          out  1   high in any state except IDLE
//  done          out  1   one-cycle pulse when verdict is valid
//  pass          out  1   1 = every |r_i| <= TOL; held until next start
//  timeout       out  1   1 = WAIT expired; held until next start
//  max_res       out  40  max |r_i|, unsigned Q24.16; held until next start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; b storage not cleared; x storage cleared.
//  FSM: IDLE -start-> SEND -16 cycles-> WAIT -out_valid-> COLLECT -16 words-> CHECK
//    -16 rows-> DONE -1 cycle-> IDLE. WAIT -TIMEOUT cycles, no out_valid-> DONE.
//  SEND: cycle after start, gsim_in_en=1 for exactly 16 consecutive cycles carrying
//   b[0]..b[15] in order. Then gsim_in_en=0; gsim_b_in=0 whenever in_en=0.
//  WAIT: counter from 0; first cycle with gsim_out_valid=1 is x[0] and is captured.
//  COLLECT: x[k] captured on the k-th consecutive valid cycle. out_valid dropping
//   mid-stream stalls capture (no skip). out_valid remaining high after x[15] is ignored.
//  CHECK: one row per cycle, row i = 0..15.
//   r_i = (b_i <<< 16) - sum_j A_ij*x_j, 40-bit signed.
//   Taps with j<0 or j>N-1 contribute 0.
//   Multiplies use shift/add only: 20=16+4, 13=8+4+1, 6=4+2.
//   |r_i| of most-negative 40-bit value saturates to 40'h7F_FFFF_FFFF.
//   Running max kept in max_res.
//  DONE: done=1 for one cycle; pass=(no timeout)&&(max_res<=TOL); on timeout max_res=0.
//  start while busy ignored; start in DONE cycle ignored; b_wr in IDLE same cycle as
//   start: write lands first, new value is sent.
//  start clears pass/timeout/max_res in the cycle after it is accepted.
//  Reset mid-operation: immediate return to IDLE, gsim_in_en=0, no done pulse.
// CONFIGURATION
//  GSIM_RES_TRACE_EN defined: extra ports res_valid(out,1), res_row(out,4),
//   res_data(out,40 signed). During CHECK, res_valid=1 each row with r_i and row index,
//   same cycle the row enters the running max. All three ports are 0 otherwise.
//  Undefined: ports absent; no trace logic.
// TESTING
//  1 Solver model returns x_j=1.0 (0x00010000) for all j; b={12,-1,5,4x10,5,-1,12}
//    -> done after CHECK, pass=1, max_res=0.
//  2 As 1 with b[7]=5 -> pass=0, max_res=40'h0000010000; trace shows row 7 r=+0x10000.
//  3 Solver model never asserts out_valid; TIMEOUT=64
//    -> done 64 cycles after WAIT entry, timeout=1, pass=0.
//  4 Assert reset at 8th SEND cycle -> gsim_in_en=0 next edge, busy=0, all flags 0, no done.
//  5 start pulse during COLLECT and b_wr to b[0]=99 during CHECK -> both ignored;
//    re-run shows original b[0].
//  6 out_valid low for 3 cycles after x[5] -> x[6..15] captured correctly; verdict as case 1.

Source files
------------

// File: rtl/gsim_host_check.sv
// Host-side driver/checker for one GSIM solve: streams b, collects x, reports the worst |b - A*x|.
// Defining GSIM_RES_TRACE_EN adds the per-row residual trace ports (res_valid/res_row/res_data).
module gsim_host_check #(
    parameter int          N       = 16,
    parameter logic [39:0] TOL     = 40'd64,
    parameter int          TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               b_wr_en,
    input  logic [3:0]         b_wr_addr,
    input  logic signed [15:0] b_wr_data,
    output logic               gsim_in_en,
    output logic signed [15:0] gsim_b_in,
    input  logic               gsim_out_valid,
    input  logic signed [31:0] gsim_x_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [39:0]        max_res
`ifdef GSIM_RES_TRACE_EN
    ,
    output logic               res_valid,
    output logic [3:0]         res_row,
    output logic signed [39:0] res_data
`endif
);
    localparam logic [3:0] LAST    = 4'(N - 1);
    localparam int         WW      = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, COLLECT, CHECK, DONE} state_t;
    state_t state;

    logic [3:0]         cnt;
    logic [WW-1:0]      wcnt;
    logic signed [15:0] b_mem [N];
    logic signed [31:0] x_mem [N];

    logic signed [39:0] tap [7];
    logic signed [39:0] s0, s1, s2, s3, ax, bsh, res;
    logic [39:0]        abs_res, new_max;

    assign busy = (state != IDLE);

    // b storage survives reset; only host writes in IDLE land.
    always_ff @(posedge clk) begin
        if (b_wr_en && state == IDLE)
            b_mem[b_wr_addr] <= b_wr_data;
    end

    // Row cnt of the 7-band product; taps falling outside 0..N-1 read as zero.
    always_comb begin
        for (int d = 0; d < 7; d++) begin
            int j;
            j = int'(cnt) + d - 3;
            tap[d] = (j >= 0 && j < N) ? 40'(x_mem[j[3:0]]) : '0;
        end
        s0  = tap[3];
        s1  = tap[2] + tap[4];
        s2  = tap[1] + tap[5];
        s3  = tap[0] + tap[6];
        ax  = (s0 <<< 4) + (s0 <<< 2) - ((s1 <<< 3) + (s1 <<< 2) + s1)
            + ((s2 <<< 2) + (s2 <<< 1)) - s3;
        bsh = {{8{b_mem[cnt][15]}}, b_mem[cnt], 16'h0};
        res = bsh - ax;
        if (res == {1'b1, 39'b0})
            abs_res = 40'h7F_FFFF_FFFF;
        else
            abs_res = res[39] ? 40'(-res) : 40'(res);
        new_max = (abs_res > max_res) ? abs_res : max_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            wcnt       <= '0;
            gsim_in_en <= 1'b0;
            gsim_b_in  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            max_res    <= '0;
            for (int k = 0; k < N; k++) x_mem[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= SEND;
                    cnt        <= '0;
                    gsim_in_en <= 1'b1;
                    // a same-cycle write to b[0] must be the value sent
                    gsim_b_in  <= (b_wr_en && b_wr_addr == 4'd0) ? b_wr_data : b_mem[0];
                    pass       <= 1'b0;
                    timeout    <= 1'b0;
                    max_res    <= '0;
                end
                SEND: if (cnt == LAST) begin
                    state      <= WAIT;
                    wcnt       <= '0;
                    gsim_in_en <= 1'b0;
                    gsim_b_in  <= '0;
                end else begin
                    cnt       <= cnt + 4'd1;
                    gsim_b_in <= b_mem[cnt + 4'd1];
                end
                WAIT: if (gsim_out_valid) begin
                    x_mem[0] <= gsim_x_out;
                    cnt      <= 4'd1;
                    state    <= COLLECT;
                end else if (wcnt == TO_LAST) begin
                    state   <= DONE;
                    done    <= 1'b1;
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                COLLECT: if (gsim_out_valid) begin
                    x_mem[cnt] <= gsim_x_out;
                    if (cnt == LAST) begin
                        state <= CHECK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CHECK: begin
                    max_res <= new_max;
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        pass  <= (new_max <= TOL);
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GSIM_RES_TRACE_EN
    assign res_valid = (state == CHECK);
    assign res_row   = res_valid ? cnt : 4'd0;
    assign res_data  = res_valid ? res : 40'sd0;
`endif
endmodule

// File: tb/tb_gsim_host_check.sv
// Randomized bench for gsim_host_check: acts as the GSIM solver and checks the verdict against a band-matrix model.
module tb_gsim_host_check;
    localparam int TO = 64;

    logic               clk = 1'b0, reset = 1'b1, start = 1'b0, b_wr_en = 1'b0;
    logic [3:0]         b_wr_addr = '0;
    logic signed [15:0] b_wr_data = '0;
    logic               gsim_in_en;
    logic signed [15:0] gsim_b_in;
    logic               gsim_out_valid = 1'b0;
    logic signed [31:0] gsim_x_out = '0;
    logic               busy, done, pass, timeout;
    logic [39:0]        max_res;
`ifdef GSIM_RES_TRACE_EN
    logic               res_valid;
    logic [3:0]         res_row;
    logic signed [39:0] res_data;
`endif

    always #5 clk = ~clk;

    gsim_host_check #(.N(16), .TOL(40'd64), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .gsim_in_en(gsim_in_en), .gsim_b_in(gsim_b_in),
        .gsim_out_valid(gsim_out_valid), .gsim_x_out(gsim_x_out),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .max_res(max_res)
`ifdef GSIM_RES_TRACE_EN
        , .res_valid(res_valid), .res_row(res_row), .res_data(res_data)
`endif
    );

    int n_chk = 0, n_ok = 0;
    logic signed [15:0] bm [16];
    logic signed [31:0] sx [16];
    longint      exp_r [16];
    logic [39:0] exp_max = '0;
    logic        exp_pass = 1'b0, exp_to = 1'b0;
    int          send_idx = 0, done_cnt = 0;
    logic        prev_done = 1'b0;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_ok++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Residual of each row from the banded matrix definition, in plain 64-bit arithmetic.
    function automatic void model();
        int     cf [7] = '{-1, 6, -13, 20, -13, 6, -1};
        longint mx, acc, a;
        mx = 0;
        for (int i = 0; i < 16; i++) begin
            acc = longint'(bm[i]) * 65536;
            for (int d = -3; d <= 3; d++)
                if (i + d >= 0 && i + d < 16) acc -= longint'(cf[d + 3]) * longint'(sx[i + d]);
            exp_r[i] = acc;
            a = (acc < 0) ? -acc : acc;
            if (a > mx) mx = a;
        end
        exp_max  = 40'(mx);
        exp_pass = (mx <= 64);
        exp_to   = 1'b0;
    endfunction

    // Per-cycle compare of everything the DUT drives.
    always @(negedge clk) begin
        if (!reset) begin
            if (gsim_in_en) begin
                if (send_idx < 16) chk("b_in", gsim_b_in, bm[send_idx]);
                else chk("send_len", send_idx, 15);
                send_idx++;
            end else begin
                chk("b_in_zero", gsim_b_in, 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_pulse", prev_done, 0);
                chk("pass", pass, exp_pass);
                chk("timeout", timeout, exp_to);
                chk("max_res", max_res, exp_max);
            end
            prev_done = done;
`ifdef GSIM_RES_TRACE_EN
            if (res_valid) chk("res_data", res_data, exp_r[res_row]);
            else chk("res_idle", {res_row, res_data}, 0);
`endif
        end
    end

    task automatic write_b(logic [3:0] a, logic signed [15:0] d);
        @(posedge clk); #1 b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d; bm[a] = d;
        @(posedge clk); #1 b_wr_en = 1'b0;
    endtask

    // mode 0: back-to-back x, 1: 3-cycle gap before x[6], 2: random gaps, 3: solver silent
    task automatic run(int mode, bit inj, bit wr_start, logic [3:0] wa, logic signed [15:0] wd);
        int d0, c, gap;
        if (wr_start) bm[wa] = wd;
        model();
        if (mode == 3) begin exp_max = '0; exp_pass = 1'b0; exp_to = 1'b1; end
        d0 = done_cnt;
        send_idx = 0;
        @(posedge clk); #1 start = 1'b1;
        if (wr_start) begin b_wr_en = 1'b1; b_wr_addr = wa; b_wr_data = wd; end
        @(posedge clk); #1 start = 1'b0; b_wr_en = 1'b0;
        @(negedge clk);
        chk("clr_pass", pass, 0); chk("clr_to", timeout, 0); chk("clr_max", max_res, 0);
        chk("busy", busy, 1);
        #1;
        c = 0;
        while (!(send_idx == 16 && !gsim_in_en) && c < 40) begin @(negedge clk); #1; c++; end
        chk("send_cnt", send_idx, 16);
        if (mode == 3) begin
            c = 0;
            while (done_cnt == d0 && c < 200) begin @(negedge clk); #1; c++; end
            chk("to_latency", c, TO);
        end else begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            for (int k = 0; k < 16; k++) begin
                gap = (mode == 1 && k == 6) ? 3 : (mode == 2 ? $urandom_range(0, 2) : 0);
                repeat (gap) begin
                    @(posedge clk); #1 gsim_out_valid = 1'b0; gsim_x_out = $urandom; start = 1'b0;
                end
                @(posedge clk); #1 gsim_out_valid = 1'b1; gsim_x_out = sx[k]; start = inj && k == 8;
            end
            // valid stays high past x[15]; a host write lands mid-CHECK when injecting
            @(posedge clk); #1 gsim_x_out = $urandom; start = 1'b0;
            if (inj) begin b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 16'sd99; end
            @(posedge clk); #1 gsim_out_valid = 1'b0; gsim_x_out = '0; b_wr_en = 1'b0;
            c = 0;
            while (done_cnt == d0 && c < 100) begin @(negedge clk); #1; c++; end
        end
        chk("done_once", done_cnt - d0, 1);
        @(negedge clk); #1;
        chk("held_pass", pass, exp_pass); chk("held_to", timeout, exp_to);
        chk("held_max", max_res, exp_max); chk("idle", busy, 0);
    endtask

    task automatic load_case1();
        logic signed [15:0] pat [16] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};
        for (int i = 0; i < 16; i++) begin
            write_b(4'(i), pat[i]);
            sx[i] = 32'sh0001_0000;
        end
    endtask

    initial begin
        int d0, c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_en", gsim_in_en, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_pass", pass, 0); chk("rst_to", timeout, 0); chk("rst_max", max_res, 0);
        #1 reset = 1'b0;

        load_case1();
        run(0, 0, 0, 0, 0);
        chk("t1_model_max", exp_max, 0);
        chk("t1_pass", pass, 1); chk("t1_max", max_res, 0);

        write_b(4'd7, 16'sd5);
        run(0, 0, 0, 0, 0);
        chk("t2_model_r7", exp_r[7], 65536);
        chk("t2_pass", pass, 0); chk("t2_max", max_res, 40'h00_0001_0000);
        write_b(4'd7, 16'sd4);

        run(3, 0, 0, 0, 0);
        chk("t3_timeout", timeout, 1); chk("t3_pass", pass, 0);

        // reset during the 8th SEND cycle
        d0 = done_cnt; send_idx = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        c = 0;
        while (send_idx < 8 && c < 40) begin @(negedge clk); #1; c++; end
        reset = 1'b1;
        @(negedge clk);
        chk("t4_in_en", gsim_in_en, 0); chk("t4_busy", busy, 0); chk("t4_done", done, 0);
        chk("t4_pass", pass, 0); chk("t4_to", timeout, 0); chk("t4_max", max_res, 0);
        #1 reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_no_done", done_cnt - d0, 0);

        run(0, 1, 0, 0, 0);
        chk("t5_pass", pass, 1);
        run(0, 0, 0, 0, 0);
        chk("t5_b0", bm[0], 12);

        run(1, 0, 0, 0, 0);
        chk("t6_pass", pass, 1); chk("t6_max", max_res, 0);

        run(0, 0, 1, 4'd0, -16'sd7);

        for (int it = 0; it < 14; it++) begin
            for (int i = 0; i < 4; i++) write_b(4'($urandom_range(0, 15)), 16'($urandom_range(0, 40)) - 16'sd20);
            for (int i = 0; i < 16; i++)
                sx[i] = (it % 4 == 3) ? 32'($urandom) : 32'sh0001_0000 + 32'($urandom_range(0, 4)) - 32'sd2;
            if (it % 3 == 0) load_case1();
            run(2, it % 5 == 2, it % 2 == 1, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 30)));
        end

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
